// File: rtl/fix_session_pkg.sv
// Shared types for the multi-host FIX session tracker.
// Session states, rx status, event codes and FIX message types.
package fix_session_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOGON_WAIT,
      ST_ACTIVE,
      ST_TESTREQ_PEND
   } sess_state_e;

   typedef enum logic [1:0] {
      RX_OK         = 2'b00,
      RX_GAP        = 2'b01,
      RX_LOW        = 2'b10,
      RX_NOT_ACTIVE = 2'b11
   } rx_status_e;

   typedef enum logic [1:0] {
      EVT_HEARTBEAT    = 2'b00,
      EVT_TEST_REQUEST = 2'b01,
      EVT_TIMEOUT      = 2'b10
   } evt_type_e;

   typedef enum logic {
      SW_IDLE,
      SW_RUN
   } sweep_state_e;

   localparam logic [3:0] MSG_LOGON        = 4'h1;
   localparam logic [3:0] MSG_HEARTBEAT    = 4'h2;
   localparam logic [3:0] MSG_TEST_REQUEST = 4'h3;
   localparam logic [3:0] MSG_LOGOUT       = 4'h4;
   localparam logic [3:0] MSG_RESEND       = 4'h5;
   localparam logic [3:0] MSG_APP          = 4'h8;

endpackage

// File: rtl/fix_session_tracker_if.sv
// rx check, tx allocation and event handshake bundle of the tracker.
// master drives requests, slave (the tracker) answers them.
interface fix_session_tracker_if #(
   parameter int HOST_W = 2,
   parameter int SEQ_W  = 32
);
   logic              rx_valid_i;
   logic [HOST_W-1:0] rx_host_i;
   logic [3:0]        rx_type_i;
   logic [SEQ_W-1:0]  rx_seq_i;
   logic              rx_done_o;
   logic [1:0]        rx_status_o;
   logic [SEQ_W-1:0]  rx_expected_o;
   logic              tx_req_i;
   logic [HOST_W-1:0] tx_host_i;
   logic              tx_seq_valid_o;
   logic [SEQ_W-1:0]  tx_seq_o;
   logic              evt_valid_o;
   logic              evt_ready_i;
   logic [HOST_W-1:0] evt_host_o;
   logic [1:0]        evt_type_o;

   modport master (
      output rx_valid_i, rx_host_i, rx_type_i, rx_seq_i,
      output tx_req_i, tx_host_i, evt_ready_i,
      input  rx_done_o, rx_status_o, rx_expected_o,
      input  tx_seq_valid_o, tx_seq_o,
      input  evt_valid_o, evt_host_o, evt_type_o
   );

   modport slave (
      input  rx_valid_i, rx_host_i, rx_type_i, rx_seq_i,
      input  tx_req_i, tx_host_i, evt_ready_i,
      output rx_done_o, rx_status_o, rx_expected_o,
      output tx_seq_valid_o, tx_seq_o,
      output evt_valid_o, evt_host_o, evt_type_o
   );

endinterface

// File: rtl/fix_session_sweep.sv
// Tick-driven host sweep: pending tick, host pointer and event slot.
// A visit that wants to raise an event waits until the slot is free.
module fix_session_sweep
   import fix_session_pkg::*;
#(
   parameter int NUM_HOST = 4,
   parameter int HOST_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_i,
   input  logic              fire,
   input  evt_type_e         fire_type,
   input  logic              evt_ready,
   output logic              visit,
   output logic [HOST_W-1:0] ptr,
   output logic              evt_valid,
   output logic [HOST_W-1:0] evt_host,
   output evt_type_e         evt_type
);
   localparam logic [HOST_W-1:0] LAST = HOST_W'(NUM_HOST - 1);

   sweep_state_e      sw, sw_n;
   logic              tick_pend, tick_pend_n;
   logic [HOST_W-1:0] ptr_n;
   logic              slot_free;

   always_comb begin
      slot_free   = !evt_valid || evt_ready;
      visit       = (sw == SW_RUN) && (!fire || slot_free);
      sw_n        = sw;
      ptr_n       = ptr;
      tick_pend_n = tick_pend | tick_i;
      unique case (sw)
         SW_IDLE: begin
            if (tick_pend) begin
               sw_n        = SW_RUN;
               ptr_n       = '0;
               tick_pend_n = tick_i;
            end
         end
         SW_RUN: begin
            if (visit) begin
               if (ptr == LAST) sw_n = SW_IDLE;
               else ptr_n = ptr + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw        <= SW_IDLE;
         ptr       <= '0;
         tick_pend <= 1'b0;
         evt_valid <= 1'b0;
         evt_host  <= '0;
         evt_type  <= EVT_HEARTBEAT;
      end else begin
         sw        <= sw_n;
         ptr       <= ptr_n;
         tick_pend <= tick_pend_n;
         if (visit && fire) begin
            evt_valid <= 1'b1;
            evt_host  <= ptr;
            evt_type  <= fire_type;
         end else if (evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fix_session_tracker.sv
// Multi-host FIX session tracker: per-host state, MsgSeqNum
// checking/allocation and idle timers feeding the event sweep.
module fix_session_tracker
   import fix_session_pkg::*;
#(
   parameter int NUM_HOST = 4,
   parameter int HOST_W   = 2,
   parameter int SEQ_W    = 32,
   parameter int TIMER_W  = 8,
   parameter int HB_INT   = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_i,
   input  logic              connected_i,
   input  logic [HOST_W-1:0] connected_host_i,
   input  logic              disconnected_i,
   input  logic [HOST_W-1:0] disconnected_host_i,
   fix_session_tracker_if.slave bus
);
   localparam logic [TIMER_W-1:0] T_MAX = '1;
   localparam logic [TIMER_W-1:0] T_HB  = TIMER_W'(HB_INT);
   localparam logic [SEQ_W-1:0]   SEQ_1 = SEQ_W'(1);

   sess_state_e        state    [NUM_HOST];
   logic [SEQ_W-1:0]   in_seq   [NUM_HOST];
   logic [SEQ_W-1:0]   out_seq  [NUM_HOST];
   logic [TIMER_W-1:0] rx_timer [NUM_HOST];
   logic [TIMER_W-1:0] tx_timer [NUM_HOST];

   logic               rx_act, tx_act, rx_clr, tx_clr;
   logic [SEQ_W-1:0]   rx_cur, tx_cur;
   rx_status_e         rx_status;
   sess_state_e        v_state, v_next;
   logic [TIMER_W-1:0] v_rx, v_tx, v_rx_n, v_tx_n;
   logic               v_fire, visit;
   evt_type_e          v_type, evt_type;
   logic [HOST_W-1:0]  ptr;

   // Out-of-range host indices match no entry and read as IDLE.
   always_comb begin
      rx_act  = 1'b0;
      rx_cur  = '0;
      tx_act  = 1'b0;
      tx_cur  = '0;
      v_state = ST_IDLE;
      v_rx    = '0;
      v_tx    = '0;
      for (int h = 0; h < NUM_HOST; h++) begin
         if (bus.rx_host_i == HOST_W'(h)) begin
            rx_act = state[h] != ST_IDLE;
            rx_cur = in_seq[h];
         end
         if (bus.tx_host_i == HOST_W'(h)) begin
            tx_act = state[h] != ST_IDLE;
            tx_cur = out_seq[h];
         end
         if (ptr == HOST_W'(h)) begin
            v_state = state[h];
            v_rx    = rx_timer[h];
            v_tx    = tx_timer[h];
         end
      end
      if (!rx_act) rx_status = RX_NOT_ACTIVE;
      else if (bus.rx_seq_i == rx_cur) rx_status = RX_OK;
      else if (bus.rx_seq_i > rx_cur) rx_status = RX_GAP;
      else rx_status = RX_LOW;
   end

   // Visit evaluation; same-cycle rx/tx clears beat the increments.
   always_comb begin
      rx_clr = bus.rx_valid_i && rx_act && bus.rx_host_i == ptr
               && (rx_status == RX_OK || rx_status == RX_GAP);
      tx_clr = bus.tx_req_i && tx_act && bus.tx_host_i == ptr;
      v_rx_n = rx_clr ? '0 : (v_rx == T_MAX ? v_rx : v_rx + 1'b1);
      v_tx_n = tx_clr ? '0 : (v_tx == T_MAX ? v_tx : v_tx + 1'b1);
      v_fire = 1'b0;
      v_type = EVT_HEARTBEAT;
      v_next = v_state;
      unique case (v_state)
         ST_IDLE: ;
         ST_LOGON_WAIT: begin
            if (v_rx_n >= T_HB) begin
               v_fire = 1'b1;
               v_type = EVT_TIMEOUT;
               v_next = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (v_rx_n >= T_HB) begin
               v_fire = 1'b1;
               v_type = EVT_TEST_REQUEST;
               v_next = ST_TESTREQ_PEND;
               v_rx_n = '0;
            end else if (v_tx_n >= T_HB) begin
               v_fire = 1'b1;
               v_tx_n = '0;
            end
         end
         ST_TESTREQ_PEND: begin
            if (v_rx_n >= T_HB) begin
               v_fire = 1'b1;
               v_type = EVT_TIMEOUT;
               v_next = ST_IDLE;
            end else if (v_tx_n >= T_HB) begin
               v_fire = 1'b1;
               v_tx_n = '0;
            end
         end
         default: ;
      endcase
   end

   fix_session_sweep #(
      .NUM_HOST (NUM_HOST),
      .HOST_W   (HOST_W)
   ) u_sweep (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick_i),
      .fire      (v_fire),
      .fire_type (v_type),
      .evt_ready (bus.evt_ready_i),
      .visit     (visit),
      .ptr       (ptr),
      .evt_valid (bus.evt_valid_o),
      .evt_host  (bus.evt_host_o),
      .evt_type  (evt_type)
   );

   assign bus.evt_type_o = evt_type;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int h = 0; h < NUM_HOST; h++) begin
            state[h]    <= ST_IDLE;
            in_seq[h]   <= SEQ_1;
            out_seq[h]  <= SEQ_1;
            rx_timer[h] <= '0;
            tx_timer[h] <= '0;
         end
      end else begin
         for (int h = 0; h < NUM_HOST; h++) begin
            if (visit && ptr == HOST_W'(h) && v_state != ST_IDLE) begin
               state[h]    <= v_next;
               rx_timer[h] <= v_rx_n;
               tx_timer[h] <= v_tx_n;
            end
            if (bus.rx_valid_i && rx_act
                && bus.rx_host_i == HOST_W'(h)) begin
               if (rx_status == RX_OK) begin
                  in_seq[h]   <= in_seq[h] + 1'b1;
                  rx_timer[h] <= '0;
                  if (bus.rx_type_i == MSG_LOGOUT)
                     state[h] <= ST_IDLE;
                  else if (state[h] == ST_LOGON_WAIT
                           && bus.rx_type_i == MSG_LOGON)
                     state[h] <= ST_ACTIVE;
                  else if (state[h] == ST_TESTREQ_PEND)
                     state[h] <= ST_ACTIVE;
               end else if (rx_status == RX_GAP) begin
                  rx_timer[h] <= '0;
               end
            end
            if (bus.tx_req_i && tx_act
                && bus.tx_host_i == HOST_W'(h)) begin
               out_seq[h]  <= out_seq[h] + 1'b1;
               tx_timer[h] <= '0;
            end
            if (connected_i && connected_host_i == HOST_W'(h)) begin
               state[h]    <= ST_LOGON_WAIT;
               in_seq[h]   <= SEQ_1;
               out_seq[h]  <= SEQ_1;
               rx_timer[h] <= '0;
               tx_timer[h] <= '0;
            end
            if (disconnected_i && disconnected_host_i == HOST_W'(h))
               state[h] <= ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rx_done_o      <= 1'b0;
         bus.rx_status_o    <= '0;
         bus.rx_expected_o  <= '0;
         bus.tx_seq_valid_o <= 1'b0;
         bus.tx_seq_o       <= '0;
      end else begin
         bus.rx_done_o      <= bus.rx_valid_i;
         bus.rx_status_o    <= bus.rx_valid_i ? rx_status : RX_OK;
         bus.rx_expected_o  <= bus.rx_valid_i ? rx_cur : '0;
         bus.tx_seq_valid_o <= bus.tx_req_i;
         bus.tx_seq_o       <= (bus.tx_req_i && tx_act) ? tx_cur : '0;
      end
   end

endmodule

// File: tb/tb_fix_session_tracker.sv
// Scoreboard bench for fix_session_tracker with a short heartbeat interval.
// Tasks push expectations; negedge monitors pop and compare.
module tb_fix_session_tracker;
   import fix_session_pkg::*;

   localparam int NUM_HOST = 4;
   localparam int HOST_W   = 2;
   localparam int SEQ_W    = 32;
   localparam int TIMER_W  = 8;
   localparam int HB_INT   = 3;

   typedef struct {
      logic [1:0]       st;
      logic [SEQ_W-1:0] ex;
      bit               chk_ex;
   } rx_exp_t;

   typedef struct {
      logic [HOST_W-1:0] h;
      logic [1:0]        t;
   } ev_exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              tick = 1'b0;
   logic              conn = 1'b0;
   logic              disc = 1'b0;
   logic [HOST_W-1:0] conn_h = '0;
   logic [HOST_W-1:0] disc_h = '0;

   int n_chk  = 0;
   int n_pass = 0;

   rx_exp_t          rx_q[$];
   logic [SEQ_W-1:0] tx_q[$];
   ev_exp_t          ev_q[$];
   rx_exp_t          rx_e;
   logic [SEQ_W-1:0] tx_e;
   ev_exp_t          ev_e;

   fix_session_tracker_if #(.HOST_W(HOST_W), .SEQ_W(SEQ_W)) bus();

   fix_session_tracker #(
      .NUM_HOST (NUM_HOST),
      .HOST_W   (HOST_W),
      .SEQ_W    (SEQ_W),
      .TIMER_W  (TIMER_W),
      .HB_INT   (HB_INT)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .tick_i              (tick),
      .connected_i         (conn),
      .connected_host_i    (conn_h),
      .disconnected_i      (disc),
      .disconnected_host_i (disc_h),
      .bus                 (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (rst && bus.rx_done_o) begin
         n_chk++;
         if (rx_q.size() == 0) begin
            $display("FAIL rx_unexpected status=%0d", bus.rx_status_o);
         end else begin
            rx_e = rx_q.pop_front();
            if (bus.rx_status_o !== rx_e.st
                || (rx_e.chk_ex && bus.rx_expected_o !== rx_e.ex))
               $display("FAIL rx_check got st=%0d exp=%0d want st=%0d exp=%0d",
                        bus.rx_status_o, bus.rx_expected_o, rx_e.st, rx_e.ex);
            else n_pass++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && bus.tx_seq_valid_o) begin
         n_chk++;
         if (tx_q.size() == 0) begin
            $display("FAIL tx_unexpected seq=%0d", bus.tx_seq_o);
         end else begin
            tx_e = tx_q.pop_front();
            if (bus.tx_seq_o !== tx_e)
               $display("FAIL tx_seq got %0d want %0d", bus.tx_seq_o, tx_e);
            else n_pass++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && bus.evt_valid_o && bus.evt_ready_i) begin
         n_chk++;
         if (ev_q.size() == 0) begin
            $display("FAIL evt_unexpected host=%0d type=%0d",
                     bus.evt_host_o, bus.evt_type_o);
         end else begin
            ev_e = ev_q.pop_front();
            if (bus.evt_host_o !== ev_e.h || bus.evt_type_o !== ev_e.t)
               $display("FAIL evt got host=%0d type=%0d want host=%0d type=%0d",
                        bus.evt_host_o, bus.evt_type_o, ev_e.h, ev_e.t);
            else n_pass++;
         end
      end
   end

   task automatic cyc(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rx_send(input logic [HOST_W-1:0] h, input logic [3:0] ty,
                          input logic [SEQ_W-1:0] seq, input logic [1:0] st,
                          input logic [SEQ_W-1:0] ex, input bit chk_ex);
      bus.rx_valid_i = 1'b1;
      bus.rx_host_i  = h;
      bus.rx_type_i  = ty;
      bus.rx_seq_i   = seq;
      rx_q.push_back('{st: st, ex: ex, chk_ex: chk_ex});
      cyc();
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic tx_send(input logic [HOST_W-1:0] h,
                          input logic [SEQ_W-1:0] ex);
      bus.tx_req_i  = 1'b1;
      bus.tx_host_i = h;
      tx_q.push_back(ex);
      cyc();
      bus.tx_req_i = 1'b0;
   endtask

   task automatic connect(input logic [HOST_W-1:0] h);
      conn   = 1'b1;
      conn_h = h;
      cyc();
      conn = 1'b0;
   endtask

   task automatic disconnect(input logic [HOST_W-1:0] h);
      disc   = 1'b1;
      disc_h = h;
      cyc();
      disc = 1'b0;
   endtask

   task automatic pulse_tick(int n = 1);
      repeat (n) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         cyc(10);
      end
   endtask

   task automatic push_evt(input logic [HOST_W-1:0] h, input logic [1:0] t);
      ev_q.push_back('{h: h, t: t});
   endtask

   task automatic wait_evt(input string name);
      int k = 0;
      while (bus.evt_valid_o !== 1'b1 && k < 20) begin
         cyc();
         k++;
      end
      n_chk++;
      if (bus.evt_valid_o !== 1'b1)
         $display("FAIL %s evt_valid timeout got %b want 1", name, bus.evt_valid_o);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cyc(3);
      n_chk++;
      if ({bus.rx_done_o, bus.rx_status_o, bus.rx_expected_o,
           bus.tx_seq_valid_o, bus.tx_seq_o} !== '0)
         $display("FAIL reset_rxtx got done=%b tx_v=%b want 0",
                  bus.rx_done_o, bus.tx_seq_valid_o);
      else n_pass++;
      n_chk++;
      if ({bus.evt_valid_o, bus.evt_host_o, bus.evt_type_o} !== '0)
         $display("FAIL reset_evt got valid=%b want 0", bus.evt_valid_o);
      else n_pass++;
      rst = 1'b1;
      cyc(2);
   endtask

   task automatic test_rx_check();
      connect(2);
      rx_send(2, MSG_LOGON, 1, RX_OK, 1, 1);
      rx_send(2, MSG_APP, 2, RX_OK, 2, 1);
      rx_send(2, MSG_APP, 5, RX_GAP, 3, 1);
      rx_send(2, MSG_APP, 2, RX_LOW, 3, 1);
      rx_send(2, MSG_APP, 3, RX_OK, 3, 1);
      rx_send(1, MSG_APP, 1, RX_NOT_ACTIVE, 0, 0);
      cyc(2);
   endtask

   task automatic test_tx_alloc();
      connect(1);
      tx_send(1, 1);
      tx_send(1, 2);
      tx_send(1, 3);
      tx_send(3, 0);
      cyc(2);
   endtask

   task automatic test_back_to_back();
      bus.rx_valid_i = 1'b1;
      bus.rx_host_i  = 2;
      bus.rx_type_i  = MSG_APP;
      bus.rx_seq_i   = 4;
      bus.tx_req_i   = 1'b1;
      bus.tx_host_i  = 2;
      rx_q.push_back('{st: RX_OK, ex: 4, chk_ex: 1});
      tx_q.push_back(1);
      cyc();
      bus.rx_seq_i = 5;
      rx_q.push_back('{st: RX_OK, ex: 5, chk_ex: 1});
      tx_q.push_back(2);
      cyc();
      bus.rx_valid_i = 1'b0;
      bus.tx_req_i   = 1'b0;
      rx_send(2, MSG_APP, 7, RX_GAP, 6, 1);
      cyc(2);
   endtask

   task automatic test_timeout();
      disconnect(1);
      disconnect(2);
      bus.evt_ready_i = 1'b1;
      connect(0);
      rx_send(0, MSG_LOGON, 1, RX_OK, 1, 1);
      push_evt(0, EVT_TEST_REQUEST);
      push_evt(0, EVT_HEARTBEAT);
      push_evt(0, EVT_TIMEOUT);
      pulse_tick(6);
      rx_send(0, MSG_APP, 2, RX_NOT_ACTIVE, 0, 0);
      n_chk++;
      if (ev_q.size() !== 0)
         $display("FAIL timeout_events left=%0d want 0", ev_q.size());
      else n_pass++;
      connect(0);
      rx_send(0, MSG_LOGON, 1, RX_OK, 1, 1);
      push_evt(0, EVT_TEST_REQUEST);
      push_evt(0, EVT_HEARTBEAT);
      pulse_tick(5);
      rx_send(0, MSG_APP, 2, RX_OK, 2, 1);
      push_evt(0, EVT_HEARTBEAT);
      pulse_tick(2);
      rx_send(0, MSG_APP, 3, RX_OK, 3, 1);
      n_chk++;
      if (ev_q.size() !== 0)
         $display("FAIL recover_events left=%0d want 0", ev_q.size());
      else n_pass++;
      disconnect(0);
      cyc(2);
   endtask

   task automatic test_stall();
      bit bad = 1'b0;
      connect(0);
      connect(3);
      rx_send(0, MSG_LOGON, 1, RX_OK, 1, 1);
      rx_send(3, MSG_LOGON, 1, RX_OK, 1, 1);
      bus.evt_ready_i = 1'b1;
      pulse_tick(2);
      bus.evt_ready_i = 1'b0;
      push_evt(0, EVT_TEST_REQUEST);
      push_evt(3, EVT_TEST_REQUEST);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      wait_evt("stall_first");
      repeat (10) begin
         cyc();
         if (bus.evt_valid_o !== 1'b1 || bus.evt_host_o !== 2'd0
             || bus.evt_type_o !== EVT_TEST_REQUEST)
            bad = 1'b1;
      end
      n_chk++;
      if (bad)
         $display("FAIL stall_hold got host=%0d type=%0d want host=0 type=1",
                  bus.evt_host_o, bus.evt_type_o);
      else n_pass++;
      bus.evt_ready_i = 1'b1;
      cyc();
      bus.evt_ready_i = 1'b0;
      n_chk++;
      if (bus.evt_valid_o !== 1'b1 || bus.evt_host_o !== 2'd3
          || bus.evt_type_o !== EVT_TEST_REQUEST)
         $display("FAIL stall_next got v=%b host=%0d type=%0d want v=1 host=3 type=1",
                  bus.evt_valid_o, bus.evt_host_o, bus.evt_type_o);
      else n_pass++;
      bus.evt_ready_i = 1'b1;
      cyc(3);
      disconnect(0);
      disconnect(3);
      cyc(2);
   endtask

   task automatic test_reset_mid();
      bus.evt_ready_i = 1'b0;
      connect(0);
      connect(2);
      rx_send(0, MSG_LOGON, 1, RX_OK, 1, 1);
      rx_send(2, MSG_LOGON, 1, RX_OK, 1, 1);
      tx_send(0, 1);
      tx_send(0, 2);
      pulse_tick(2);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      wait_evt("midreset_evt");
      rst = 1'b0;
      #1;
      n_chk++;
      if ({bus.evt_valid_o, bus.evt_host_o, bus.evt_type_o,
           bus.rx_done_o, bus.tx_seq_valid_o, bus.tx_seq_o} !== '0)
         $display("FAIL midreset_out got evt_v=%b host=%0d want 0",
                  bus.evt_valid_o, bus.evt_host_o);
      else n_pass++;
      cyc(2);
      rst = 1'b1;
      bus.evt_ready_i = 1'b1;
      cyc(2);
      tx_send(0, 0);
      rx_send(2, MSG_APP, 1, RX_NOT_ACTIVE, 0, 0);
      connect(0);
      tx_send(0, 1);
      rx_send(0, MSG_LOGON, 1, RX_OK, 1, 1);
      cyc(3);
   endtask

   initial begin
      bus.rx_valid_i  = 1'b0;
      bus.rx_host_i   = '0;
      bus.rx_type_i   = '0;
      bus.rx_seq_i    = '0;
      bus.tx_req_i    = 1'b0;
      bus.tx_host_i   = '0;
      bus.evt_ready_i = 1'b0;
      test_reset();
      test_rx_check();
      test_tx_alloc();
      test_back_to_back();
      test_timeout();
      test_stall();
      test_reset_mid();
      n_chk++;
      if (rx_q.size() + tx_q.size() + ev_q.size() !== 0)
         $display("FAIL drain got rx=%0d tx=%0d evt=%0d want 0",
                  rx_q.size(), tx_q.size(), ev_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fix_session_tracker.md
Name: fix_session_tracker

Overview:
Multi-host FIX session state and sequence tracker, parametrised in host count, sequence width and heartbeat interval. Replaces the single-host sequence generator and the hard-wired timeout in the engine top level. Holds per-host session state, expected-incoming and next-outgoing MsgSeqNum, and rx/tx idle timers. Checks incoming sequence numbers, allocates outgoing ones, and raises heartbeat, test-request and timeout events to the session manager through a valid/ready port.

Parameters:
NUM_HOST, 4, number of tracked host sessions (>=2)
HOST_W, 2, host index width, equals clog2(NUM_HOST)
SEQ_W, 32, MsgSeqNum width
TIMER_W, 8, idle-timer width in ticks
HB_INT, 30, heartbeat interval in ticks (1..2^TIMER_W-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
tick_i  in  1  one-cycle timebase pulse (1 s)
connected_i  in  1  pulse: TCP session up for connected_host_i
connected_host_i  in  HOST_W  host of connected_i
disconnected_i  in  1  pulse: TCP session down for disconnected_host_i
disconnected_host_i  in  HOST_W  host of disconnected_i
rx_valid_i  in  1  parsed incoming message header available
rx_host_i  in  HOST_W  source host
rx_type_i  in  4  message type code (package)
rx_seq_i  in  SEQ_W  received MsgSeqNum
rx_done_o  out  1  check result valid, one cycle after rx_valid_i
rx_status_o  out  2  00 OK, 01 GAP, 10 LOW, 11 NOT_ACTIVE
rx_expected_o  out  SEQ_W  expected number before the update
tx_req_i  in  1  allocate outgoing MsgSeqNum
tx_host_i  in  HOST_W  destination host
tx_seq_valid_o  out  1  allocation result, one cycle after tx_req_i
tx_seq_o  out  SEQ_W  allocated number
evt_valid_o  out  1  event pending
evt_ready_i  in  1  consumer accepts event
evt_host_o  out  HOST_W  event host
evt_type_o  out  2  00 HEARTBEAT, 01 TEST_REQUEST, 10 TIMEOUT

Behaviour:
- Reset (rst low, async): all hosts IDLE; in_seq=1, out_seq=1, timers=0; all outputs 0; sweep idle; tick_pend=0.
- Per-host states: IDLE, LOGON_WAIT, ACTIVE, TESTREQ_PEND.
- connected_i: host goes to LOGON_WAIT from any state; in_seq=out_seq=1; timers=0.
- disconnected_i: host goes to IDLE. connect and disconnect for the same host in the same cycle: disconnect wins.
- rx check, registered, 1-cycle latency:
  - Host IDLE: status NOT_ACTIVE, no update.
  - rx_seq==in_seq: OK, in_seq+1 (wraps mod 2^SEQ_W), rx_timer=0.
  - rx_seq>in_seq: GAP, in_seq unchanged, rx_timer=0.
  - rx_seq<in_seq: LOW, no update.
  - On OK: LOGON in LOGON_WAIT goes to ACTIVE. Any type in TESTREQ_PEND goes to ACTIVE. LOGOUT goes to IDLE.
  - rx_valid_i is accepted every cycle; no back-pressure.
- tx alloc, 1-cycle latency: tx_seq_o=out_seq, then out_seq+1 (wraps), tx_timer=0. Allowed in LOGON_WAIT/ACTIVE/TESTREQ_PEND. In IDLE, tx_seq_o=0 and no update.
- rx and tx for the same host in the same cycle: both applied.
- Sweep: tick_i sets tick_pend. When tick_pend and sweep idle, the sweep visits hosts 0..NUM_HOST-1, one per cycle, and clears tick_pend at start. A tick arriving mid-sweep sets tick_pend again. Further ticks before the next sweep starts are merged.
- Visit, non-IDLE host only:
  - Increment rx_timer and tx_timer, each saturating.
  - LOGON_WAIT, rx_timer>=HB_INT: TIMEOUT, host goes to IDLE.
  - ACTIVE, rx_timer>=HB_INT: TEST_REQUEST, host goes to TESTREQ_PEND, rx_timer=0.
  - TESTREQ_PEND, rx_timer>=HB_INT: TIMEOUT, host goes to IDLE.
  - Else ACTIVE/TESTREQ_PEND with tx_timer>=HB_INT: HEARTBEAT, tx_timer=0.
  - At most one event per visit. A deferred heartbeat fires on a later visit because tx_timer saturates.
- Event slot: single entry, holds while evt_valid_o && !evt_ready_i. The sweep stalls on its current host while the slot is full. The transfer cycle frees the slot for the same-cycle visit.
- Conflicts with a visit: rx/tx clears in the same cycle win over sweep increments for that host. connected_i/disconnected_i win over a sweep transition. A stalled visit re-evaluates the current state.
- Host indices >=NUM_HOST on any input are ignored. rx_done_o reports NOT_ACTIVE for them.

Decomposition:
- Package fix_session_pkg:
  - Session state enum.
  - rx status codes.
  - Event codes.
  - Message type codes: LOGON=4'h1, HEARTBEAT=4'h2, TEST_REQUEST=4'h3, LOGOUT=4'h4, RESEND=4'h5, APP=4'h8.
- Sub-module fix_session_sweep: tick_pend, host pointer, stall logic and the event slot. Per-host register arrays and the rx/tx paths stay in the top.

Test Plan:
- Reset, connect host 2, rx LOGON seq 1 -> rx_done_o next cycle, status OK, expected 1; host 2 ACTIVE; next rx seq 2 -> OK, expected 2.
- Host 2 ACTIVE, rx seq 5 with in_seq=3 -> GAP, expected 3; then seq 2 -> LOW; in_seq stays 3.
- Three tx_req_i to host 1 after connect -> tx_seq_o 1, 2, 3 on consecutive cycles; tx_req_i to an IDLE host -> tx_seq_o 0.
- HB_INT=3, host 0 ACTIVE, no traffic, evt_ready_i=1:
  - tick 3 -> TEST_REQUEST, host 0.
  - 3 more ticks -> TIMEOUT, host 0 IDLE.
  - rx at tick 2 of the second interval -> no TIMEOUT, host ACTIVE.
- Hosts 0 and 3 both due for TEST_REQUEST, evt_ready_i held low 10 cycles -> host 0 event held stable; host 3 event follows one cycle after the handshake.
- Assert rst low mid-sweep with evt_valid_o=1 -> all outputs 0 immediately; all hosts IDLE; sequence numbers 1 after release.
